// File: rtl/imm_rot_encoder_if.sv
// Start/done handshake bundle for imm_rot_encoder, plus the FSM state for debug visibility.
// Handshake: startIn is sampled only while busyOut=0; doneOut pulses for one cycle when results are valid.
interface imm_rot_encoder_if;
  logic        startIn;
  logic [31:0] valueIn;
  logic        busyOut;
  logic        doneOut;
  logic        okOut;
  logic [11:0] shiftOperandOut;
  logic        invertOut;
  logic [1:0]  dbgState;

  modport master (
    output startIn, valueIn,
    input  busyOut, doneOut, okOut, shiftOperandOut, invertOut, dbgState
  );

  modport slave (
    input  startIn, valueIn,
    output busyOut, doneOut, okOut, shiftOperandOut, invertOut, dbgState
  );
endinterface

// File: rtl/imm_rot_encoder.sv
// Iterative 32-bit constant -> {rotate_imm, immed_8} encoder, one rotation tried per clock.
// Optional macro IMM_ROT_ENCODER_INVERT_EN adds a second pass on ~value (MOV->MVN).
module imm_rot_encoder (
  input  logic               clk,
  input  logic               rst,
  imm_rot_encoder_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_v, w_v_nxt;
  logic [3:0]  r_r, w_r_nxt;
  logic        r_ok, w_ok_nxt;
  logic [11:0] r_shift, w_shift_nxt;
  logic [4:0]  w_sh;
  logic [31:0] w_t;
`ifdef IMM_ROT_ENCODER_INVERT_EN
  logic        r_p, w_p_nxt;
  logic        r_inv, w_inv_nxt;
`endif

  // Rotate left by 2*r; a zero shift makes the right-shift term vanish.
  assign w_sh = {r_r, 1'b0};
  assign w_t  = (r_v << w_sh) | (r_v >> (6'd32 - {1'b0, w_sh}));

  always_comb begin
    w_state_nxt = r_state;
    w_v_nxt     = r_v;
    w_r_nxt     = r_r;
    w_ok_nxt    = r_ok;
    w_shift_nxt = r_shift;
`ifdef IMM_ROT_ENCODER_INVERT_EN
    w_p_nxt     = r_p;
    w_inv_nxt   = r_inv;
`endif
    case (r_state)
      IDLE: begin
        if (bus.startIn) begin
          w_state_nxt = SEARCH;
          w_v_nxt     = bus.valueIn;
          w_r_nxt     = 4'd0;
          w_ok_nxt    = 1'b0;
          w_shift_nxt = 12'd0;
`ifdef IMM_ROT_ENCODER_INVERT_EN
          w_p_nxt     = 1'b0;
          w_inv_nxt   = 1'b0;
`endif
        end
      end
      SEARCH: begin
        if (w_t[31:8] == 24'd0) begin
          w_shift_nxt = {r_r, w_t[7:0]};
          w_ok_nxt    = 1'b1;
`ifdef IMM_ROT_ENCODER_INVERT_EN
          w_inv_nxt   = r_p;
`endif
          w_state_nxt = DONE;
        end else if (r_r != 4'hF) begin
          w_r_nxt = r_r + 4'd1;
        end else begin
`ifdef IMM_ROT_ENCODER_INVERT_EN
          if (!r_p) begin
            w_v_nxt = ~r_v;
            w_r_nxt = 4'd0;
            w_p_nxt = 1'b1;
          end else begin
            w_ok_nxt    = 1'b0;
            w_shift_nxt = 12'd0;
            w_state_nxt = DONE;
          end
`else
          w_ok_nxt    = 1'b0;
          w_shift_nxt = 12'd0;
          w_state_nxt = DONE;
`endif
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_v     <= 32'd0;
      r_r     <= 4'd0;
      r_ok    <= 1'b0;
      r_shift <= 12'd0;
`ifdef IMM_ROT_ENCODER_INVERT_EN
      r_p     <= 1'b0;
      r_inv   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_v     <= w_v_nxt;
      r_r     <= w_r_nxt;
      r_ok    <= w_ok_nxt;
      r_shift <= w_shift_nxt;
`ifdef IMM_ROT_ENCODER_INVERT_EN
      r_p     <= w_p_nxt;
      r_inv   <= w_inv_nxt;
`endif
    end
  end

  assign bus.busyOut         = (r_state != IDLE);
  assign bus.doneOut         = (r_state == DONE);
  assign bus.okOut           = r_ok;
  assign bus.shiftOperandOut = r_shift;
  assign bus.dbgState        = r_state;
`ifdef IMM_ROT_ENCODER_INVERT_EN
  assign bus.invertOut       = r_inv;
`else
  assign bus.invertOut       = 1'b0;
`endif

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Scoreboard bench for imm_rot_encoder: expected {latency, invert, ok, operand} queued at issue,
// popped and compared by a monitor whenever doneOut is seen.
module tb_imm_rot_encoder;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  imm_rot_encoder_if bus_if ();

  imm_rot_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef IMM_ROT_ENCODER_INVERT_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  // packed expectation: {lat[5:0], inv, ok, operand[11:0]}
  logic [19:0] exp_q[$];
  int          acc_q[$];
  logic [19:0] last_exp;

  // ---------------- golden model ----------------
  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    int k;
    k = s % 32;
    if (k == 0) return x;
    return (x >> k) | (x << (32 - k));
  endfunction

  // Try every rotation; a candidate byte is accepted only if expanding it reproduces the value.
  function automatic logic [19:0] model(input logic [31:0] val);
    logic [31:0] v, rl, back;
    logic [7:0]  imm;
    logic [5:0]  lat;
    logic [3:0]  rr;
    for (int p = 0; p < NPASS; p++) begin
      v = (p == 1) ? ~val : val;
      for (int r = 0; r < 16; r++) begin
        rl   = ror32(v, 32 - 2 * r);
        imm  = rl[7:0];
        back = ror32({24'd0, imm}, 2 * r);
        if (back == v) begin
          lat = 6'(p * 16 + r + 1);
          rr  = 4'(r);
          return {lat, p[0], 1'b1, rr, imm};
        end
      end
    end
    lat = 6'(NPASS * 16);
    return {lat, 1'b0, 1'b0, 12'd0};
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic prev_done;
  always @(negedge clk) begin
    logic [19:0] e;
    logic [19:0] g;
    int a;
    if (!rst) begin
      prev_done <= 1'b0;
    end else begin
      prev_done <= bus_if.doneOut;
      if (bus_if.doneOut) begin
        n_checks++;
        if (prev_done) begin
          n_fail++;
          $display("FAIL done_pulse_width: doneOut high two cycles in a row at cycle %0d", cyc);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: doneOut with empty scoreboard at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          g = {6'(cyc - a), bus_if.invertOut, bus_if.okOut, bus_if.shiftOperandOut};
          if (g !== e) begin
            n_fail++;
            $display("FAIL result: got lat=%0d inv=%0b ok=%0b op=%03h, want lat=%0d inv=%0b ok=%0b op=%03h",
                     g[19:14], g[13], g[12], g[11:0], e[19:14], e[13], e[12], e[11:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [31:0] val);
    last_exp = model(val);
    exp_q.push_back(last_exp);
    acc_q.push_back(cyc + 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus_if.busyOut && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bus_if.busyOut) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busyOut still high after %0d cycles", n);
    end
  endtask

  // Issue one request, confirm results clear on accept, then confirm they hold afterwards.
  task automatic run_one(input logic [31:0] val);
    @(negedge clk);
    wait_idle();
    bus_if.startIn = 1'b1;
    bus_if.valueIn = val;
    push_exp(val);
    @(negedge clk);
    bus_if.startIn = 1'b0;
    bus_if.valueIn = $urandom;
    check("clear_on_accept", {19'd0, bus_if.invertOut, bus_if.okOut, bus_if.shiftOperandOut}, 32'd0);
    wait_idle();
    repeat (3) @(negedge clk);
    check("held_result", {19'd0, bus_if.invertOut, bus_if.okOut, bus_if.shiftOperandOut},
          {19'd0, last_exp[13:0]});
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] hs_vals[5];
  logic [31:0] rv;

  initial begin
    int acc_n;
    int idx;
    int n;
    cyc       = 0;
    n_checks  = 0;
    n_fail    = 0;
    prev_done = 1'b0;
    rst       = 1'b0;
    bus_if.startIn = 1'b0;
    bus_if.valueIn = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus_if.busyOut, bus_if.doneOut, bus_if.okOut, bus_if.invertOut,
                            bus_if.shiftOperandOut}, 32'd0);
    rst = 1'b1;

    // Reset in the middle of a search.
    @(negedge clk);
    bus_if.startIn = 1'b1;
    bus_if.valueIn = 32'h0000_0101;
    @(negedge clk);
    bus_if.startIn = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_mid_search", {31'd0, bus_if.busyOut}, 32'd1);
    rst = 1'b0;
    #1;
    check("async_reset_outputs", {bus_if.busyOut, bus_if.doneOut, bus_if.okOut, bus_if.invertOut,
                                  bus_if.shiftOperandOut}, 32'd0);
    check("async_reset_state", {30'd0, bus_if.dbgState}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed vectors.
    run_one(32'h0000_00FF);
    run_one(32'hFF00_0000);
    run_one(32'hF000_000F);
    run_one(32'h0000_03FC);
    run_one(32'h0000_0101);
    run_one(32'h0000_01FE);
    run_one(32'hFFFF_FF00);
    run_one(32'h0000_0000);
    run_one(32'hFFFF_FFFF);
    run_one(32'h8000_0000);
    run_one(32'h0000_0001);

    // Continuous start with a value that changes every cycle.
    hs_vals[0] = 32'h0000_00FF;
    hs_vals[1] = 32'hFF00_0000;
    hs_vals[2] = 32'h0000_0012;
    hs_vals[3] = 32'hF000_000F;
    hs_vals[4] = 32'h0000_03FC;
    wait_idle();
    acc_n = 0;
    idx   = 0;
    @(negedge clk);
    n = 0;
    while (acc_n < 6 && n < 400) begin
      bus_if.startIn = 1'b1;
      bus_if.valueIn = hs_vals[idx % 5];
      idx++;
      if (!bus_if.busyOut) begin
        push_exp(bus_if.valueIn);
        acc_n++;
      end
      @(negedge clk);
      n++;
    end
    bus_if.startIn = 1'b0;
    check("hs_accepts", acc_n, 6);
    wait_idle();
    repeat (3) @(negedge clk);
    check("hs_held_result", {19'd0, bus_if.invertOut, bus_if.okOut, bus_if.shiftOperandOut},
          {19'd0, last_exp[13:0]});

    // Sweep: raw random, constructed encodable, and complements of encodable values.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0:       rv = $urandom;
        1:       rv = ror32({24'd0, 8'($urandom_range(0, 255))}, 2 * $urandom_range(0, 15));
        default: rv = ~ror32({24'd0, 8'($urandom_range(0, 255))}, 2 * $urandom_range(0, 15));
      endcase
      run_one(rv);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
